// File: rtl/gpio_pkg.sv
// Shared constants and index helpers for the GPIO pin arbiter.
package gpio_pkg;

    localparam int DEF_NUM_PINS    = 32;
    localparam int DEF_NUM_CORES   = 4;
    localparam int DEF_NUM_SM      = 4;
    localparam int DEF_SYNC_STAGES = 2;

    function automatic int csel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sm_idx(
        input int c,
        input int s,
        input int p,
        input int nsm   = DEF_NUM_SM,
        input int npins = DEF_NUM_PINS
    );
        return ((c * nsm) + s) * npins + p;
    endfunction

endpackage

// File: rtl/gpio_arbiter_if.sv
// State-machine side bundle of the pin arbiter: selects, strobes, pin state.
interface gpio_arbiter_if
    import gpio_pkg::*;
#(
    parameter int NUM_PINS  = DEF_NUM_PINS,
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int NUM_SM    = DEF_NUM_SM
);

    localparam int CSEL_W = csel_w(NUM_CORES);
    localparam int NW     = NUM_CORES * NUM_SM * NUM_PINS;

    logic [NUM_PINS*CSEL_W-1:0] core_select;
    logic [NW-1:0]              sm_out_wr;
    logic [NW-1:0]              sm_out_val;
    logic [NW-1:0]              sm_oe_wr;
    logic [NW-1:0]              sm_oe_val;
    logic [NUM_PINS-1:0]        gpio_output;
    logic [NUM_PINS-1:0]        gpio_drive;
    logic [NUM_PINS-1:0]        pin_switched;

    modport master (
        output core_select, sm_out_wr, sm_out_val,
        output sm_oe_wr, sm_oe_val,
        input  gpio_output, gpio_drive, pin_switched
    );

    modport slave (
        input  core_select, sm_out_wr, sm_out_val,
        input  sm_oe_wr, sm_oe_val,
        output gpio_output, gpio_drive, pin_switched
    );

endinterface

// File: rtl/gpio_pin_slice.sv
// One pin: core select tracking, highest-SM arbitration, out/oe regs, sync.
module gpio_pin_slice
    import gpio_pkg::*;
#(
    parameter int NUM_CORES   = DEF_NUM_CORES,
    parameter int NUM_SM      = DEF_NUM_SM,
    parameter int CSEL_W      = csel_w(NUM_CORES),
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CSEL_W-1:0]           core_select_i,
    input  logic [NUM_CORES*NUM_SM-1:0] out_wr_i,
    input  logic [NUM_CORES*NUM_SM-1:0] out_val_i,
    input  logic [NUM_CORES*NUM_SM-1:0] oe_wr_i,
    input  logic [NUM_CORES*NUM_SM-1:0] oe_val_i,
    input  logic                        pin_in_i,
    input  logic                        sync_bypass_i,
    output logic                        gpio_output_o,
    output logic                        gpio_drive_o,
    output logic                        pin_switched_o,
    output logic                        in_data_o
);

    logic [CSEL_W-1:0]      sel_q, sel_d;
    logic                   out_q, out_d;
    logic                   oe_q, oe_d;
    logic                   sw_q, sw_d;
    logic                   hit;
    logic [SYNC_STAGES-1:0] sync_q;

    always_comb begin
        sel_d = sel_q;
        out_d = out_q;
        oe_d  = oe_q;
        sw_d  = 1'b0;
        hit   = 1'b0;
        if (core_select_i != sel_q) begin
            sel_d = core_select_i;
            oe_d  = 1'b0;
            sw_d  = 1'b1;
        end else begin
            for (int c = 0; c < NUM_CORES; c++) begin
                if (sel_q == CSEL_W'(c)) begin
                    hit = 1'b1;
                    // ascending scan: the highest set strobe is applied last
                    for (int s = 0; s < NUM_SM; s++) begin
                        if (out_wr_i[c*NUM_SM+s]) out_d = out_val_i[c*NUM_SM+s];
                        if (oe_wr_i[c*NUM_SM+s])  oe_d  = oe_val_i[c*NUM_SM+s];
                    end
                end
            end
            if (!hit) oe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q  <= '0;
            out_q  <= 1'b0;
            oe_q   <= 1'b0;
            sw_q   <= 1'b0;
            sync_q <= '0;
        end else begin
            sel_q     <= sel_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            sw_q      <= sw_d;
            sync_q[0] <= pin_in_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign gpio_output_o  = out_q;
    assign gpio_drive_o   = oe_q;
    assign pin_switched_o = sw_q;
    assign in_data_o      = sync_bypass_i ? pin_in_i : sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_arbiter.sv
// Pin arbiter top: slices the flat strobe buses per pin, one slice per pin.
module gpio_arbiter
    import gpio_pkg::*;
#(
    parameter int NUM_PINS    = DEF_NUM_PINS,
    parameter int NUM_CORES   = DEF_NUM_CORES,
    parameter int NUM_SM      = DEF_NUM_SM,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    gpio_arbiter_if.slave       bus,
    input  logic [NUM_PINS-1:0] pin_in,
    input  logic [NUM_PINS-1:0] sync_bypass,
    output logic [NUM_PINS-1:0] in_data
);

    localparam int CSEL_W = csel_w(NUM_CORES);
    localparam int NW     = NUM_CORES * NUM_SM;

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        logic [NW-1:0] out_wr_p, out_val_p, oe_wr_p, oe_val_p;

        for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
            for (genvar s = 0; s < NUM_SM; s++) begin : g_sm
                localparam int K = sm_idx(c, s, p, NUM_SM, NUM_PINS);
                assign out_wr_p[c*NUM_SM+s]  = bus.sm_out_wr[K];
                assign out_val_p[c*NUM_SM+s] = bus.sm_out_val[K];
                assign oe_wr_p[c*NUM_SM+s]   = bus.sm_oe_wr[K];
                assign oe_val_p[c*NUM_SM+s]  = bus.sm_oe_val[K];
            end
        end

        gpio_pin_slice #(
            .NUM_CORES  (NUM_CORES),
            .NUM_SM     (NUM_SM),
            .CSEL_W     (CSEL_W),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_slice (
            .clk           (clk),
            .rst           (rst),
            .core_select_i (bus.core_select[p*CSEL_W +: CSEL_W]),
            .out_wr_i      (out_wr_p),
            .out_val_i     (out_val_p),
            .oe_wr_i       (oe_wr_p),
            .oe_val_i      (oe_val_p),
            .pin_in_i      (pin_in[p]),
            .sync_bypass_i (sync_bypass[p]),
            .gpio_output_o (bus.gpio_output[p]),
            .gpio_drive_o  (bus.gpio_drive[p]),
            .pin_switched_o(bus.pin_switched[p]),
            .in_data_o     (in_data[p])
        );
    end

endmodule

// File: tb/tb_gpio_arbiter.sv
// Directed bench: default 32x4x4 instance plus a small 8-pin 3x2 instance.
module tb_gpio_arbiter;
    import gpio_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    gpio_arbiter_if #(.NUM_PINS(32), .NUM_CORES(4), .NUM_SM(4)) bus_a ();
    gpio_arbiter_if #(.NUM_PINS(8), .NUM_CORES(3), .NUM_SM(2)) bus_b ();

    logic [31:0] pin_in_a, byp_a, in_a;
    logic [7:0]  pin_in_b, byp_b, in_b;

    gpio_arbiter #(
        .NUM_PINS(32), .NUM_CORES(4), .NUM_SM(4), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .pin_in(pin_in_a), .sync_bypass(byp_a), .in_data(in_a)
    );

    gpio_arbiter #(
        .NUM_PINS(8), .NUM_CORES(3), .NUM_SM(2), .SYNC_STAGES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .pin_in(pin_in_b), .sync_bypass(byp_b), .in_data(in_b)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_a();
        bus_a.sm_out_wr  = '0;
        bus_a.sm_out_val = '0;
        bus_a.sm_oe_wr   = '0;
        bus_a.sm_oe_val  = '0;
    endtask

    task automatic wr_a(input int c, input int s, input int p,
                        input bit is_oe, input bit val);
        int k;
        k = sm_idx(c, s, p, 4, 32);
        if (is_oe) begin
            bus_a.sm_oe_wr[k]  = 1'b1;
            bus_a.sm_oe_val[k] = val;
        end else begin
            bus_a.sm_out_wr[k]  = 1'b1;
            bus_a.sm_out_val[k] = val;
        end
    endtask

    initial begin
        rst = 1'b0;
        clr_a();
        for (int i = 0; i < 64; i++) bus_a.core_select[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 512; i++) begin
            bus_a.sm_out_wr[i]  = 1'($urandom_range(0, 1));
            bus_a.sm_out_val[i] = 1'($urandom_range(0, 1));
            bus_a.sm_oe_wr[i]   = 1'($urandom_range(0, 1));
            bus_a.sm_oe_val[i]  = 1'($urandom_range(0, 1));
        end
        pin_in_a = $urandom;
        byp_a    = '0;
        bus_b.core_select = '0;
        bus_b.sm_out_wr   = '1;
        bus_b.sm_out_val  = '1;
        bus_b.sm_oe_wr    = '1;
        bus_b.sm_oe_val   = '1;
        pin_in_b = 8'hFF;
        byp_b    = '0;
        repeat (3) step();
        check("rst_out_a", 64'(bus_a.gpio_output), 64'h0);
        check("rst_oe_a", 64'(bus_a.gpio_drive), 64'h0);
        check("rst_sw_a", 64'(bus_a.pin_switched), 64'h0);
        check("rst_in_a", 64'(in_a), 64'h0);
        check("rst_out_b", 64'(bus_b.gpio_output), 64'h0);
        check("rst_oe_b", 64'(bus_b.gpio_drive), 64'h0);
        check("rst_in_b", 64'(in_b), 64'h0);

        clr_a();
        bus_a.core_select = '0;
        pin_in_a = '0;
        bus_b.sm_out_wr  = '0;
        bus_b.sm_out_val = '0;
        bus_b.sm_oe_wr   = '0;
        bus_b.sm_oe_val  = '0;
        pin_in_b = '0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("release_sw_a", 64'(bus_a.pin_switched), 64'h0);
        end

        wr_a(0, 1, 5, 1'b0, 1'b0);
        wr_a(0, 3, 5, 1'b0, 1'b1);
        wr_a(0, 2, 5, 1'b1, 1'b1);
        step();
        clr_a();
        check("prio_out", 64'(bus_a.gpio_output), 64'h20);
        check("prio_oe", 64'(bus_a.gpio_drive), 64'h20);
        repeat (10) step();
        check("hold_out", 64'(bus_a.gpio_output), 64'h20);
        check("hold_oe", 64'(bus_a.gpio_drive), 64'h20);

        wr_a(0, 0, 5, 1'b0, 1'b1);
        wr_a(0, 2, 5, 1'b0, 1'b0);
        step();
        clr_a();
        check("prio_rev_out", 64'(bus_a.gpio_output), 64'h0);
        wr_a(0, 3, 5, 1'b0, 1'b1);
        step();
        clr_a();
        check("prio_restore", 64'(bus_a.gpio_output), 64'h20);

        wr_a(2, 0, 5, 1'b1, 1'b0);
        wr_a(1, 3, 5, 1'b0, 1'b0);
        wr_a(3, 3, 5, 1'b1, 1'b0);
        step();
        clr_a();
        check("foreign_oe", 64'(bus_a.gpio_drive), 64'h20);
        check("foreign_out", 64'(bus_a.gpio_output), 64'h20);

        bus_a.core_select[10 +: 2] = 2'd2;
        wr_a(2, 0, 5, 1'b1, 1'b1);
        wr_a(2, 0, 5, 1'b0, 1'b0);
        step();
        clr_a();
        check("sw_oe", 64'(bus_a.gpio_drive), 64'h0);
        check("sw_pulse", 64'(bus_a.pin_switched), 64'h20);
        check("sw_out_held", 64'(bus_a.gpio_output), 64'h20);
        wr_a(2, 1, 5, 1'b1, 1'b1);
        wr_a(2, 1, 5, 1'b0, 1'b0);
        step();
        clr_a();
        check("new_core_oe", 64'(bus_a.gpio_drive), 64'h20);
        check("new_core_out", 64'(bus_a.gpio_output), 64'h0);
        check("sw_pulse_end", 64'(bus_a.pin_switched), 64'h0);

        bus_a.core_select[10 +: 2] = 2'd3;
        step();
        check("dbl_sw1", 64'(bus_a.pin_switched), 64'h20);
        check("dbl_oe1", 64'(bus_a.gpio_drive), 64'h0);
        bus_a.core_select[10 +: 2] = 2'd2;
        wr_a(2, 0, 5, 1'b1, 1'b1);
        step();
        clr_a();
        check("dbl_sw2", 64'(bus_a.pin_switched), 64'h20);
        check("dbl_oe2", 64'(bus_a.gpio_drive), 64'h0);

        pin_in_a[7] = 1'b1;
        step();
        check("sync_1edge", 64'(in_a[7]), 64'h0);
        step();
        check("sync_2edge", 64'(in_a[7]), 64'h1);
        byp_a[7] = 1'b1;
        pin_in_a[7] = 1'b0;
        #1;
        check("bypass_lo", 64'(in_a[7]), 64'h0);
        pin_in_a[7] = 1'b1;
        #1;
        check("bypass_hi", 64'(in_a[7]), 64'h1);
        byp_a[7] = 1'b0;
        pin_in_a[7] = 1'b0;

        wr_a(2, 0, 5, 1'b1, 1'b1);
        wr_a(2, 0, 5, 1'b0, 1'b1);
        step();
        clr_a();
        check("pre_rst_oe", 64'(bus_a.gpio_drive), 64'h20);
        bus_a.core_select[10 +: 2] = 2'd1;
        #2;
        rst = 1'b0;
        #1;
        check("midsw_rst_oe", 64'(bus_a.gpio_drive), 64'h0);
        check("midsw_rst_out", 64'(bus_a.gpio_output), 64'h0);
        step();
        rst = 1'b1;
        step();
        check("rel_sw_pulse", 64'(bus_a.pin_switched), 64'h20);
        check("rel_sw_oe", 64'(bus_a.gpio_drive), 64'h0);
        bus_a.core_select[10 +: 2] = 2'd0;
        step();
        check("back_core0", 64'(bus_a.pin_switched), 64'h20);
        wr_a(0, 3, 5, 1'b1, 1'b1);
        step();
        clr_a();
        check("core0_oe", 64'(bus_a.gpio_drive), 64'h20);

        bus_b.core_select[6 +: 2] = 2'd2;
        step();
        check("b_sw3", 64'(bus_b.pin_switched), 64'h08);
        bus_b.sm_out_wr[sm_idx(2, 0, 3, 2, 8)]  = 1'b1;
        bus_b.sm_out_wr[sm_idx(2, 1, 3, 2, 8)]  = 1'b1;
        bus_b.sm_out_val[sm_idx(2, 1, 3, 2, 8)] = 1'b1;
        bus_b.sm_oe_wr[sm_idx(2, 1, 3, 2, 8)]   = 1'b1;
        bus_b.sm_oe_val[sm_idx(2, 1, 3, 2, 8)]  = 1'b1;
        step();
        bus_b.sm_out_wr = '0;
        bus_b.sm_oe_wr  = '0;
        check("b_out3", 64'(bus_b.gpio_output), 64'h08);
        check("b_oe3", 64'(bus_b.gpio_drive), 64'h08);
        bus_b.core_select[4 +: 2] = 2'd3;
        step();
        check("b_sw2", 64'(bus_b.pin_switched), 64'h04);
        bus_b.sm_out_wr  = '1;
        bus_b.sm_out_val = '1;
        bus_b.sm_oe_wr   = '1;
        bus_b.sm_oe_val  = '1;
        repeat (3) step();
        check("b_oor_out", 64'(bus_b.gpio_output), 64'hFB);
        check("b_oor_oe", 64'(bus_b.gpio_drive), 64'hFB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_arbiter.md
# gpio_arbiter

Parametrised pin arbiter between the state-machine cores and the pads, replacing the fixed 32-pin, 4×4 combinational output arbitration. It gives each pin a registered output value and drive enable with sticky state. Within the selected core, the highest-numbered state machine wins. Core reassignment is glitch-safe, and each pin has a per-pin configurable input synchroniser. It sits between the FSM array and the `gpio` pad block.

## Interface
- `NUM_PINS`, 32, number of GPIO pins
- `NUM_CORES`, 4, number of cores
- `NUM_SM`, 4, state machines per core
- `SYNC_STAGES`, 2, input synchroniser depth (≥1)
- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-low reset
- `core_select` in NUM_PINS*CSEL_W: per-pin core index, pin p at bits [p*CSEL_W +: CSEL_W], CSEL_W = max(1, clog2(NUM_CORES))
- `sm_out_wr` in NUM_CORES*NUM_SM*NUM_PINS: per-SM, per-pin output-value write strobe, index ((c*NUM_SM)+s)*NUM_PINS+p
- `sm_out_val` in NUM_CORES*NUM_SM*NUM_PINS: output value written when strobe set
- `sm_oe_wr` in NUM_CORES*NUM_SM*NUM_PINS: per-SM, per-pin drive-enable write strobe
- `sm_oe_val` in NUM_CORES*NUM_SM*NUM_PINS: drive-enable value written when strobe set
- `pin_in` in NUM_PINS: raw pad input, asynchronous to clk
- `sync_bypass` in NUM_PINS: 1 = pass `pin_in` straight to `in_data`
- `gpio_output` out NUM_PINS: registered pin output value
- `gpio_drive` out NUM_PINS: registered pin drive enable
- `in_data` out NUM_PINS: synchronised or bypassed input
- `pin_switched` out NUM_PINS: one-cycle pulse when a pin's core assignment changes

## Operation
- Each pin has `sel_q` (CSEL_W), `out_q`, `oe_q`, and SYNC_STAGES sync flops. Every pin is independent.
- **Switch.** If `core_select[p] != sel_q[p]`:
  - `sel_q` loads the new value, `oe_q` clears to 0, and `out_q` holds.
  - `pin_switched[p]` is 1 for that cycle.
  - All writes to pin p are discarded that cycle.
- **Normal.** Otherwise, with c = `sel_q[p]`:
  - Output value: if any `sm_out_wr[c][s][p]` is set, the highest s among the set strobes is the winner and `out_q` loads that SM's `sm_out_val`. If none is set, `out_q` holds.
  - Drive enable: `oe_q` updates from `sm_oe_wr`/`sm_oe_val` by the same rule, arbitrated independently of the output value.
  - Strobes from cores other than c are ignored.
- **Out-of-range select** (`sel_q` ≥ NUM_CORES): all writes are ignored and `oe_q` is forced to 0 each cycle.
- **Outputs:** `gpio_output = out_q`, `gpio_drive = oe_q`.
- **Input path:**
  - Sync chain shifts `pin_in` every cycle.
  - `in_data[p]` = `sync_bypass[p]` ? `pin_in[p]` : last sync stage.
  - Bypass is a combinational path by design.
- **Reset** (asynchronous assert, `rst` = 0): `sel_q`, `out_q`, `oe_q`, and all sync flops go to 0. `pin_switched` = 0.
- **Reset release:** any pin with nonzero `core_select` takes the switch path on the first clock.

## Timing
- Write at edge n shows on `gpio_output`/`gpio_drive` after edge n+1 (1-cycle latency).
- Switch:
  - `core_select` changes before edge n: `gpio_drive` = 0 after edge n.
  - The new core's first write is accepted at edge n+1 and visible after it.
- If the select changes and then changes back within one cycle, each change is its own switch event with its own blanking cycle.
- Synchronised input: a `pin_in` change is visible on `in_data` after SYNC_STAGES edges. Bypass: same cycle.
- Reset mid-switch: reset wins, and the pin resumes at core 0 with drive off.

## Structure
- Shared package `gpio_pkg` holds:
  - default parameter constants
  - CSEL_W function
  - flat-index helper function `sm_idx(c, s, p)`
- Sub-module `gpio_pin_slice` contains one pin's select, arbitration, out/oe registers, and synchroniser. The top level is a generate loop over NUM_PINS plus strobe slicing.

## Test plan
- **Reset:** hold `rst`=0 with random inputs → all outputs 0. Release with `core_select` = 0 → `pin_switched` stays 0.
- **Priority:** core 0, pin 5, SM1 and SM3 both write out (SM1 val=0, SM3 val=1) plus oe=1 → next cycle `gpio_output[5]`=1, `gpio_drive[5]`=1. No strobes for 10 cycles → values hold.
- **Foreign core:** `sel_q[5]`=0, core 2 SM0 writes oe=1 → `gpio_drive[5]` unchanged.
- **Switch:** pin 5 driven by core 0, `core_select[5]`→2 with core 2 strobes asserted the same cycle → next cycle `gpio_drive[5]`=0, `pin_switched[5]`=1, `gpio_output[5]` held. Core 2 oe write the following cycle → `gpio_drive[5]`=1.
- **Sync:** SYNC_STAGES=2, `pin_in[7]` 0→1 → `in_data[7]`=1 exactly 2 edges later. With `sync_bypass[7]`=1 → same cycle.
- **Parameters:** NUM_PINS=8, NUM_CORES=3, NUM_SM=2, `core_select`=3 → writes ignored, `gpio_drive` forced 0.
